// File: rtl/midi_pkg.sv
// Shared constants and FSM encodings for the MIDI note receiver.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    P_WAIT_STATUS = 2'd0,
    P_WAIT_NOTE   = 2'd1,
    P_WAIT_VEL    = 2'd2
  } parse_state_e;

  function automatic logic is_status(input logic [7:0] b);
    return b[7];
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial byte receiver: 2-FF synchronizer, start-bit qualification,
// centre sampling, byte strobe and framing-error pulse.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o,
  output logic       framing_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic [2:0]    sync_q;
  logic          line_s, fall_s;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
  assign line_s = sync_q[1];
  assign fall_s = sync_q[2] & ~sync_q[1];

  // Synchronizer and receive state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Byte FSM next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = line_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {line_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (line_s) begin
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: state_d = line_s ? RX_IDLE : RX_WAIT_HIGH;
      default:      state_d = RX_IDLE;
    endcase
  end

  assign byte_o        = shift_q;
  assign byte_done_o   = done_q;
  assign framing_err_o = ferr_q;

endmodule

// File: rtl/midi_note_rx.sv
// MIDI Note On/Off receiver with running status and monophonic last-note priority.
// Define MIDI_OMNI_EN to accept all 16 channels instead of CHANNEL only.
module midi_note_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] velocity,
  output logic       framing_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic [1:0]   rst_sync_q;
  logic         rst_int_n;
  logic [7:0]   rx_byte_s;
  logic         rx_done_s, rx_ferr_s, chan_ok_s;
  parse_state_e state_q, state_d;
  logic         rs_valid_q, rs_valid_d, rs_on_q, rs_on_d;
  logic [7:0]   note_q, note_d, data_q, data_d, vel_q, vel_d;
  logic         valid_q, valid_d;

  // Reset synchronizer: asynchronous assert, synchronous release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk          (clk),
    .rst_n        (rst_int_n),
    .rx_i         (midi_rx),
    .byte_o       (rx_byte_s),
    .byte_done_o  (rx_done_s),
    .framing_err_o(rx_ferr_s)
  );

`ifdef MIDI_OMNI_EN
  assign chan_ok_s = 1'b1;
`else
  localparam logic [3:0] CHAN = 4'(CHANNEL);
  assign chan_ok_s = (rx_byte_s[3:0] == CHAN);
`endif

  // Parser and note output registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= P_WAIT_STATUS;
      rs_valid_q <= 1'b0;
      rs_on_q    <= 1'b0;
      note_q     <= 8'h00;
      data_q     <= 8'h00;
      vel_q      <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_valid_q <= rs_valid_d;
      rs_on_q    <= rs_on_d;
      note_q     <= note_d;
      data_q     <= data_d;
      vel_q      <= vel_d;
      valid_q    <= valid_d;
    end
  end

  // Parser next-state and message execution
  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_on_d    = rs_on_q;
    note_d     = note_q;
    data_d     = data_q;
    vel_d      = vel_q;
    valid_d    = valid_q;
    if (rx_ferr_s) begin
      state_d = rs_valid_q ? P_WAIT_NOTE : P_WAIT_STATUS;
    end else if (rx_done_s) begin
      if (rx_byte_s >= MIDI_RT_MIN) begin
        state_d = state_q;
      end else if (is_status(rx_byte_s)) begin
        if (chan_ok_s && (rx_byte_s[7:4] == MIDI_NOTE_ON || rx_byte_s[7:4] == MIDI_NOTE_OFF)) begin
          rs_valid_d = 1'b1;
          rs_on_d    = (rx_byte_s[7:4] == MIDI_NOTE_ON);
          state_d    = P_WAIT_NOTE;
        end else begin
          rs_valid_d = 1'b0;
          state_d    = P_WAIT_STATUS;
        end
      end else begin
        case (state_q)
          P_WAIT_NOTE: begin
            note_d  = rx_byte_s;
            state_d = P_WAIT_VEL;
          end
          P_WAIT_VEL: begin
            state_d = P_WAIT_NOTE;
            if (rs_on_q && rx_byte_s != 8'h00) begin
              data_d  = note_q;
              vel_d   = rx_byte_s;
              valid_d = 1'b1;
            end else if (valid_q && note_q == data_q) begin
              valid_d = 1'b0;
            end else begin
              valid_d = valid_q;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  assign midi_data   = data_q;
  assign velocity    = vel_q;
  assign midi_valid  = valid_q;
  assign framing_err = rx_ferr_s;

endmodule
